// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store memory arbiter.
package mem_port_arbiter_pkg;

  localparam int XLEN = 32;

  // Arbiter state encoding, kept as plain constants for legacy tooling.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_D = 2'd1;
  localparam logic [1:0] ST_BUSY_I = 2'd2;

  // Which requester currently owns the memory transaction.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_DATA  = 2'd1,
    OWN_FETCH = 2'd2
  } owner_t;

  // Watchdog counter width: enough to hold TIMEOUT, never narrower than 1 bit.
  function automatic int timer_width(input int timeout);
    if (timeout < 1) return 1;
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_bus_timer.sv
// Saturating bus watchdog counter. Cleared while the bus is idle, counts
// busy cycles without acknowledge, flags the last permitted cycle.
module bus_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              TW   = timer_width(TIMEOUT);
  localparam logic [TW-1:0]   LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0]   SAT  = '1;

  logic [TW-1:0] r_count;

  // Count busy cycles; hold at all-ones so the value can never wrap to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != SAT)) begin
      r_count <= r_count + TW'(1);
    end
  end

  // A TIMEOUT of zero disables the watchdog entirely.
  assign expired = (TIMEOUT != 0) && (r_count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one single-port memory between the fetch
// port and the load/store port (data wins), with a registered memory
// handshake, a stall output to the core and a bus-timeout watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN_P  = XLEN,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [XLEN_P-1:0] if_addr,
  output logic [XLEN_P-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN_P-1:0] d_addr,
  input  logic [XLEN_P-1:0] d_wdata,
  output logic [XLEN_P-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN_P-1:0] mem_addr,
  output logic [XLEN_P-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN_P-1:0] mem_rdata,
  output logic              stall,
  output logic              bus_err
);

  logic [1:0]        r_state;
  owner_t            r_owner;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [XLEN_P-1:0] r_mem_addr;
  logic [XLEN_P-1:0] r_mem_wdata;
  logic [XLEN_P-1:0] r_if_rdata;
  logic [XLEN_P-1:0] r_d_rdata;
  logic              r_if_valid;
  logic              r_d_valid;
  logic              r_bus_err;

  logic w_busy;
  logic w_expired;

  assign w_busy = (r_state != ST_IDLE);

  bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_bus_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (~w_busy),
    .enable  (w_busy & ~mem_ack),
    .expired (w_expired)
  );

  // Arbitrate in IDLE, hold the request while busy, finish on ack or abort.
  // NOTE: every register here is written with <= so all updates in this block
  // see the pre-edge values of each other, exactly like the flops they become.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_NONE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      // Completion strobes are single-cycle pulses by default.
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_bus_err  <= 1'b0;
      if (!w_busy) begin
        // A stray mem_ack while idle falls through here and is ignored.
        if (d_req) begin
          r_state     <= ST_BUSY_D;
          r_owner     <= OWN_DATA;
          r_mem_req   <= 1'b1;
          r_mem_we    <= d_we;
          r_mem_addr  <= d_addr;
          r_mem_wdata <= d_wdata;
        end else if (if_req) begin
          r_state     <= ST_BUSY_I;
          r_owner     <= OWN_FETCH;
          r_mem_req   <= 1'b1;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= if_addr;
          r_mem_wdata <= '0;
        end
      end else if (mem_ack || w_expired) begin
        // Ack takes precedence over an expiry landing on the same edge.
        r_state   <= ST_IDLE;
        r_owner   <= OWN_NONE;
        r_mem_req <= 1'b0;
        r_bus_err <= ~mem_ack;
        if (r_owner == OWN_DATA) begin
          r_d_valid <= 1'b1;
          if (!r_mem_we) begin
            r_d_rdata <= mem_ack ? mem_rdata : '0;
          end
        end else begin
          r_if_valid <= 1'b1;
          r_if_rdata <= mem_ack ? mem_rdata : '0;
        end
      end
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign d_rdata   = r_d_rdata;
  assign d_valid   = r_d_valid;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign bus_err   = r_bus_err;

  // Stall while a request is pending and not yet answered; forced low during
  // reset so every output is 0 as soon as reset asserts.
  assign stall = ~reset & ((d_req & ~r_d_valid) | (if_req & ~r_if_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. A second instance with a
// short watchdog exercises the timeout path.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;

  // Main instance (TIMEOUT = 16).
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, mem_req, mem_we, stall, bus_err;

  // Watchdog instance (TIMEOUT = 4).
  logic        t_if_req, t_d_req, t_d_we, t_mem_ack;
  logic [31:0] t_if_addr, t_d_addr, t_d_wdata, t_mem_rdata;
  logic [31:0] t_if_rdata, t_d_rdata, t_mem_addr, t_mem_wdata;
  logic        t_if_valid, t_d_valid, t_mem_req, t_mem_we, t_stall, t_bus_err;

  int n_checks = 0;
  int n_errors = 0;
  int if_valid_seen = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .bus_err(bus_err)
  );

  mem_port_arbiter #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset),
    .if_req(t_if_req), .if_addr(t_if_addr), .if_rdata(t_if_rdata), .if_valid(t_if_valid),
    .d_req(t_d_req), .d_we(t_d_we), .d_addr(t_d_addr), .d_wdata(t_d_wdata),
    .d_rdata(t_d_rdata), .d_valid(t_d_valid),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_ack(t_mem_ack), .mem_rdata(t_mem_rdata), .stall(t_stall), .bus_err(t_bus_err)
  );

  // Count every fetch completion pulse seen over the whole run.
  always @(negedge clk) if (if_valid) if_valid_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    t_if_req = 0; t_d_req = 0; t_d_we = 0; t_mem_ack = 0;
    t_if_addr = 0; t_d_addr = 0; t_d_wdata = 0; t_mem_rdata = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'b0, mem_req}, 0);
    check("rst_stall", {31'b0, stall}, 0);
    check("rst_valids", {29'b0, if_valid, d_valid, bus_err}, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;

    // Fetch only.
    @(negedge clk);
    if_req = 1; if_addr = 32'h0000_0010;
    #1 check("f_stall_req", {31'b0, stall}, 1);
    @(negedge clk);
    check("f_mem_req", {31'b0, mem_req}, 1);
    check("f_mem_addr", mem_addr, 32'h10);
    check("f_mem_we", {31'b0, mem_we}, 0);
    check("f_stall_busy", {31'b0, stall}, 1);
    mem_ack = 1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    check("f_if_valid", {31'b0, if_valid}, 1);
    check("f_if_rdata", if_rdata, 32'h0050_0093);
    check("f_stall_valid", {31'b0, stall}, 0);
    check("f_mem_req_done", {31'b0, mem_req}, 0);
    if_req = 0; mem_ack = 0;
    @(negedge clk);
    check("f_if_valid_once", {31'b0, if_valid}, 0);

    // Variable latency load: ack on the fifth busy cycle.
    d_req = 1; d_we = 0; d_addr = 32'h3000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("vl_mem_req", {31'b0, mem_req}, 1);
      check("vl_mem_addr", mem_addr, 32'h3000);
      check("vl_d_valid", {31'b0, d_valid}, 0);
      if (i == 4) begin mem_ack = 1; mem_rdata = 32'h1234_5678; end
    end
    @(negedge clk);
    check("vl_d_valid_pulse", {31'b0, d_valid}, 1);
    check("vl_d_rdata", d_rdata, 32'h1234_5678);
    check("vl_bus_err", {31'b0, bus_err}, 0);
    d_req = 0; mem_ack = 0;
    @(negedge clk);
    check("vl_d_valid_once", {31'b0, d_valid}, 0);

    // Contention: store and fetch together, data first.
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    if_req = 1; if_addr = 32'h0000_0040;
    @(negedge clk);
    check("c_mem_we", {31'b0, mem_we}, 1);
    check("c_mem_addr", mem_addr, 32'h2000);
    check("c_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("c_d_valid", {31'b0, d_valid}, 1);
    check("c_if_valid_wait", {31'b0, if_valid}, 0);
    check("c_store_keeps_rdata", d_rdata, 32'h1234_5678);
    check("c_stall_fetch_pending", {31'b0, stall}, 1);
    d_req = 0; d_we = 0; mem_ack = 0;
    @(negedge clk);
    check("c_fetch_grant", {31'b0, mem_req}, 1);
    check("c_fetch_addr", mem_addr, 32'h40);
    check("c_fetch_we", {31'b0, mem_we}, 0);
    mem_ack = 1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    check("c_if_valid", {31'b0, if_valid}, 1);
    check("c_if_rdata", if_rdata, 32'h1111_2222);
    if_req = 0; mem_ack = 0;
    @(negedge clk);

    // Watchdog instance: a good load first, then a load that never acks.
    t_d_req = 1; t_d_we = 0; t_d_addr = 32'h4000;
    @(negedge clk);
    t_mem_ack = 1; t_mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("t_ok_valid", {31'b0, t_d_valid}, 1);
    check("t_ok_rdata", t_d_rdata, 32'hCAFE_F00D);
    check("t_ok_bus_err", {31'b0, t_bus_err}, 0);
    t_d_req = 0; t_mem_ack = 0;
    @(negedge clk);
    t_d_req = 1; t_d_addr = 32'h4004;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t_busy_mem_req", {31'b0, t_mem_req}, 1);
      check("t_busy_no_valid", {31'b0, t_d_valid}, 0);
    end
    @(negedge clk);
    check("t_abort_mem_req", {31'b0, t_mem_req}, 0);
    check("t_abort_valid", {31'b0, t_d_valid}, 1);
    check("t_abort_bus_err", {31'b0, t_bus_err}, 1);
    check("t_abort_rdata", t_d_rdata, 0);
    t_d_req = 0;
    @(negedge clk);
    check("t_after_valid", {31'b0, t_d_valid}, 0);
    check("t_after_bus_err", {31'b0, t_bus_err}, 0);
    t_mem_ack = 1; t_mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t_stray_ack_valid", {31'b0, t_d_valid}, 0);
    check("t_stray_ack_req", {31'b0, t_mem_req}, 0);
    t_mem_ack = 0;

    // Reset in the middle of a fetch.
    if_req = 1; if_addr = 32'h0000_0080;
    @(negedge clk);
    check("r_busy_mem_req", {31'b0, mem_req}, 1);
    #2 reset = 1'b1;
    #1;
    check("r_async_mem_req", {31'b0, mem_req}, 0);
    check("r_async_if_valid", {31'b0, if_valid}, 0);
    check("r_async_stall", {31'b0, stall}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("r_refetch_req", {31'b0, mem_req}, 1);
    check("r_refetch_addr", mem_addr, 32'h80);
    mem_ack = 1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    check("r_refetch_valid", {31'b0, if_valid}, 1);
    if_req = 0; mem_ack = 0;
    @(negedge clk);

    // Eight back-to-back fetches with if_req held high.
    if_req = 1; if_addr = 32'h100;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("b_mem_req", {31'b0, mem_req}, 1);
      check("b_mem_addr", mem_addr, 32'h100 + 32'(4 * k));
      check("b_busy_no_valid", {31'b0, if_valid}, 0);
      check("b_stall_busy", {31'b0, stall}, 1);
      mem_ack = 1; mem_rdata = 32'hA0 + 32'(k);
      @(negedge clk);
      check("b_if_valid", {31'b0, if_valid}, 1);
      check("b_if_rdata", if_rdata, 32'hA0 + 32'(k));
      check("b_mem_req_low", {31'b0, mem_req}, 0);
      mem_ack = 0;
      if_addr = 32'h100 + 32'(4 * (k + 1));
      if (k == 7) if_req = 0;
    end
    repeat (2) @(negedge clk);
    check("b_idle_after", {31'b0, mem_req}, 0);
    // 1 plain fetch + 1 contention fetch + 1 post-reset fetch + 8 back-to-back.
    check("if_valid_total", 32'(if_valid_seen), 11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
